// File: rtl/vga_text_pixel_pipe_if.sv
// Bundle between the text renderer, the sync generator it follows and its two memories.
// slave = renderer side, master = environment side.
interface vga_text_pixel_pipe_if;
  logic [9:0]  x_px_i;
  logic [9:0]  y_px_i;
  logic        activevideo_i;
  logic        hsync_i;
  logic        vsync_i;
  logic [11:0] char_addr_o;
  logic [15:0] char_data_i;
  logic [11:0] font_addr_o;
  logic [7:0]  font_data_i;
  logic        cursor_en_i;
  logic [6:0]  cursor_col_i;
  logic [4:0]  cursor_row_i;
  logic [11:0] rgb_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        activevideo_o;

  modport slave (
    input  x_px_i, y_px_i, activevideo_i, hsync_i, vsync_i,
    input  char_data_i, font_data_i,
    input  cursor_en_i, cursor_col_i, cursor_row_i,
    output char_addr_o, font_addr_o,
    output rgb_o, hsync_o, vsync_o, activevideo_o
  );

  modport master (
    output x_px_i, y_px_i, activevideo_i, hsync_i, vsync_i,
    output char_data_i, font_data_i,
    output cursor_en_i, cursor_col_i, cursor_row_i,
    input  char_addr_o, font_addr_o,
    input  rgb_o, hsync_o, vsync_o, activevideo_o
  );
endinterface

// File: rtl/vga_text_pixel_pipe.sv
// 8x16 text-mode renderer: char fetch -> glyph fetch -> colour, with syncs delayed to match
// the 3-cycle pipeline and a frame-timed blinking underline cursor.
module vga_text_pixel_pipe #(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  vga_text_pixel_pipe_if.slave  bus
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned CNT_W = $clog2(BLINK_FRAMES);

  logic [6:0]       w_col;
  logic [ROW_W-1:0] w_row;
  logic [11:0]      w_addr;
  logic             w_cur_hit;
  logic             w_pix;
  logic             w_vs_fall;

  logic [11:0] r_char_addr;
  logic [2:0]  r1_xsub;
  logic [3:0]  r1_ysub;
  logic        r1_act, r1_hs, r1_vs, r1_cur;

  logic [11:0] r_font_addr;
  logic [3:0]  r2_fg, r2_bg;
  logic [2:0]  r2_xsub;
  logic        r2_act, r2_hs, r2_vs, r2_cur;

  logic [11:0] r_rgb;
  logic        r_hs, r_vs, r_act;

  logic             r_vs_prev;
  logic             r_blink_on;
  logic [CNT_W-1:0] r_frame_cnt;

  // 4-bit IRGB index to 12-bit colour; index 6 is brown rather than dark yellow
  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [3:0] lo;
    logic [3:0] r, g, b;
    lo = idx[3] ? 4'h5 : 4'h0;
    r  = (idx[2] ? 4'hA : 4'h0) + lo;
    g  = (idx[1] ? 4'hA : 4'h0) + lo;
    b  = (idx[0] ? 4'hA : 4'h0) + lo;
    if (idx == 4'd6) g = 4'h5;
    return {r, g, b};
  endfunction

  assign w_col = bus.x_px_i[9:3];
  assign w_row = ROW_W'(bus.y_px_i[9:4]);

  // Rows beyond the screen still produce an address; memory aliasing is accepted.
  if (COLS == 80) begin : g_addr_shift
    assign w_addr = 12'({w_row, 6'b0}) + 12'({w_row, 4'b0}) + 12'(w_col);
  end else begin : g_addr_mul
    assign w_addr = 12'(w_row * COLS + w_col);
  end

  assign w_cur_hit = bus.cursor_en_i & r_blink_on
                   & (w_col == bus.cursor_col_i)
                   & (w_row == ROW_W'(bus.cursor_row_i))
                   & (bus.y_px_i[3:0] >= 4'd14);

  assign w_pix     = bus.font_data_i[3'(3'd7 - r2_xsub)] | r2_cur;
  assign w_vs_fall = r_vs_prev & ~bus.vsync_i;

  // Three-stage fetch/render pipeline; sync bits idle high through reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_char_addr <= '0;
      r1_xsub     <= '0;
      r1_ysub     <= '0;
      r1_act      <= 1'b0;
      r1_hs       <= 1'b1;
      r1_vs       <= 1'b1;
      r1_cur      <= 1'b0;
      r_font_addr <= '0;
      r2_fg       <= '0;
      r2_bg       <= '0;
      r2_xsub     <= '0;
      r2_act      <= 1'b0;
      r2_hs       <= 1'b1;
      r2_vs       <= 1'b1;
      r2_cur      <= 1'b0;
      r_rgb       <= '0;
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
      r_act       <= 1'b0;
    end else begin
      r_char_addr <= w_addr;
      r1_xsub     <= bus.x_px_i[2:0];
      r1_ysub     <= bus.y_px_i[3:0];
      r1_act      <= bus.activevideo_i;
      r1_hs       <= bus.hsync_i;
      r1_vs       <= bus.vsync_i;
      r1_cur      <= w_cur_hit;

      r_font_addr <= {bus.char_data_i[7:0], r1_ysub};
      r2_fg       <= bus.char_data_i[11:8];
      r2_bg       <= bus.char_data_i[15:12];
      r2_xsub     <= r1_xsub;
      r2_act      <= r1_act;
      r2_hs       <= r1_hs;
      r2_vs       <= r1_vs;
      r2_cur      <= r1_cur;

      r_rgb       <= r2_act ? palette(w_pix ? r2_fg : r2_bg) : 12'h000;
      r_hs        <= r2_hs;
      r_vs        <= r2_vs;
      r_act       <= r2_act;
    end
  end

  // Frame counter advanced on each vsync falling edge; blink phase flips on wrap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vs_prev   <= 1'b1;
      r_frame_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else begin
      r_vs_prev <= bus.vsync_i;
      if (w_vs_fall) begin
        if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= '0;
          r_blink_on  <= ~r_blink_on;
        end else begin
          r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.char_addr_o   = r_char_addr;
  assign bus.font_addr_o   = r_font_addr;
  assign bus.rgb_o         = r_rgb;
  assign bus.hsync_o       = r_hs;
  assign bus.vsync_o       = r_vs;
  assign bus.activevideo_o = r_act;

endmodule

// File: tb/tb_vga_text_pixel_pipe.sv
// Bench for vga_text_pixel_pipe: directed and random pixel streams checked against a
// per-pixel text-mode model with combinational-read memories behind the address registers.
module tb_vga_text_pixel_pipe;

  localparam int BLINK = 32;
  localparam logic [11:0] PAL [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  typedef struct {
    logic [11:0] addr;
    logic [11:0] faddr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        act;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vga_text_pixel_pipe_if bus ();

  vga_text_pixel_pipe dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] text_mem [4096];
  logic [7:0]  font_rom [4096];

  assign bus.char_data_i = text_mem[bus.char_addr_o];
  assign bus.font_data_i = font_rom[bus.font_addr_o];

  int   n_pass  = 0;
  int   n_total = 0;
  int   n_fail  = 0;
  exp_t q[$];
  int   edges   = 0;
  bit   prev_vs = 1'b1;
  bit   cur_en  = 1'b0;
  int   cur_col = 0;
  int   cur_row = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected pipeline result for one sampled pixel, straight from the text-mode rules
  function automatic exp_t model(input int x, input int y, input bit a, input bit h, input bit v);
    exp_t        e;
    int          col, row, gr, addr, faddr;
    logic [15:0] w;
    logic [7:0]  g;
    bit          blink, hit, on;
    col   = x / 8;
    row   = (y / 16) % 32;
    gr    = y % 16;
    addr  = (row * 80 + col) % 4096;
    w     = text_mem[addr];
    faddr = int'(w[7:0]) * 16 + gr;
    g     = font_rom[faddr];
    blink = ((edges / BLINK) % 2) == 0;
    hit   = cur_en && blink && (col == cur_col) && (row == cur_row) && (gr >= 14);
    on    = g[7 - (x % 8)] || hit;
    e.addr  = 12'(addr);
    e.faddr = 12'(faddr);
    e.rgb   = a ? PAL[on ? w[11:8] : w[15:12]] : 12'h000;
    e.hs    = h;
    e.vs    = v;
    e.act   = a;
    return e;
  endfunction

  task automatic check_outputs();
    chk("char_addr", 16'(bus.char_addr_o), 16'(q[2].addr));
    chk("font_addr", 16'(bus.font_addr_o), 16'(q[1].faddr));
    chk("rgb",       16'(bus.rgb_o),       16'(q[0].rgb));
    chk("hsync",     16'(bus.hsync_o),     16'(q[0].hs));
    chk("vsync",     16'(bus.vsync_o),     16'(q[0].vs));
    chk("active",    16'(bus.activevideo_o), 16'(q[0].act));
    if (!bus.activevideo_o) chk("blank_rgb", 16'(bus.rgb_o), 16'h0000);
  endtask

  task automatic drive(input int x, input int y, input bit a, input bit h, input bit v);
    bus.x_px_i        = 10'(x);
    bus.y_px_i        = 10'(y);
    bus.activevideo_i = a;
    bus.hsync_i       = h;
    bus.vsync_i       = v;
    bus.cursor_en_i   = cur_en;
    bus.cursor_col_i  = 7'(cur_col);
    bus.cursor_row_i  = 5'(cur_row);
  endtask

  // One pixel clock: check what has emerged, then present the next pixel
  task automatic step(input int x, input int y, input bit a, input bit h, input bit v);
    @(negedge clk);
    check_outputs();
    drive(x, y, a, h, v);
    void'(q.pop_front());
    q.push_back(model(x, y, a, h, v));
    if (prev_vs && !v) edges++;
    prev_vs = v;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic vs_edges(input int n);
    repeat (n) begin
      step(0, 0, 1'b0, 1'b1, 1'b0);
      step(0, 0, 1'b0, 1'b1, 1'b1);
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must drop to reset values without a clock edge
  task automatic do_reset(input int hold);
    exp_t e;
    @(negedge clk);
    #2;
    rst = 1'b1;
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("rst_char_addr", 16'(bus.char_addr_o), 16'h0000);
    chk("rst_font_addr", 16'(bus.font_addr_o), 16'h0000);
    chk("rst_rgb",       16'(bus.rgb_o),       16'h0000);
    chk("rst_hsync",     16'(bus.hsync_o),     16'h0001);
    chk("rst_vsync",     16'(bus.vsync_o),     16'h0001);
    chk("rst_active",    16'(bus.activevideo_o), 16'h0000);
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    edges   = 0;
    prev_vs = 1'b1;
    q.delete();
    e = model(0, 0, 1'b0, 1'b1, 1'b1);
    repeat (3) q.push_back(e);
  endtask

  task automatic cursor_pixel(input logic [11:0] exp, input string tag);
    step(40, 46, 1'b1, 1'b1, 1'b1);
    idle(3);
    chk(tag, 16'(bus.rgb_o), 16'(exp));
  endtask

  localparam int H_ACT = 96, H_FP = 4, H_SW = 8, H_BP = 4;
  localparam int V_ACT = 40, V_FP = 2, V_SW = 2, V_BP = 3;
  localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;

  initial begin
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4096; i++) begin
      text_mem[i] = 16'($urandom);
      font_rom[i] = 8'($urandom);
    end
    text_mem[162]     = 16'h1F41;
    font_rom[12'h413] = 8'h20;
    text_mem[165]     = 16'h1641;
    font_rom[12'h41E] = 8'h00;

    do_reset(2);

    // Idle blanking, then a single hsync pulse must surface three clocks later
    idle(6);
    step(0, 0, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk("hs_before", 16'(bus.hsync_o), 16'h0001);
    idle(1);
    chk("hs_lat3", 16'(bus.hsync_o), 16'h0000);
    idle(3);

    // Character cell lookup: bg pixel then fg pixel of the same glyph row
    step(17, 35, 1'b1, 1'b1, 1'b1);
    idle(1);
    chk("addr_162", 16'(bus.char_addr_o), 16'd162);
    idle(1);
    chk("faddr_413", 16'(bus.font_addr_o), 16'h0413);
    idle(1);
    chk("rgb_bg", 16'(bus.rgb_o), 16'h000A);
    step(18, 35, 1'b1, 1'b1, 1'b1);
    idle(3);
    chk("rgb_fg", 16'(bus.rgb_o), 16'h0FFF);

    // Blinking underline cursor
    cur_en  = 1'b1;
    cur_col = 5;
    cur_row = 2;
    cursor_pixel(12'hA50, "cursor_on0");
    vs_edges(BLINK);
    cursor_pixel(12'h00A, "cursor_off32");
    vs_edges(BLINK);
    cursor_pixel(12'hA50, "cursor_on64");
    vs_edges(BLINK);
    cursor_pixel(12'h00A, "cursor_off96");
    do_reset(1);
    cursor_pixel(12'hA50, "cursor_after_rst");

    // Random pixels, positions (including off-screen rows) and cursor settings
    for (int i = 0; i < 3000; i++) begin
      int x, y;
      x = (i % 7 == 0) ? int'($urandom_range(1023)) : int'($urandom_range(639));
      y = (i % 7 == 0) ? int'($urandom_range(1023)) : int'($urandom_range(479));
      cur_en  = $urandom_range(3) != 0;
      cur_col = $urandom_range(1) ? x / 8 : int'($urandom_range(127));
      cur_row = $urandom_range(1) ? (y / 16) % 32 : int'($urandom_range(31));
      step(x, y, 1'($urandom), ($urandom_range(7) != 0), ($urandom_range(3) != 0));
    end
    idle(3);

    // Continuous frames from a scaled-down sync generator
    cur_en  = 1'b1;
    cur_col = 3;
    cur_row = 1;
    for (int f = 0; f < 2; f++) begin
      for (int ly = 0; ly < V_TOT; ly++) begin
        for (int px = 0; px < H_TOT; px++) begin
          bit a, h, v;
          a = (px < H_ACT) && (ly < V_ACT);
          h = !((px >= H_ACT + H_FP) && (px < H_ACT + H_FP + H_SW));
          v = !((ly >= V_ACT + V_FP) && (ly < V_ACT + V_FP + V_SW));
          step(a ? px : 0, a ? ly : 0, a, h, v);
        end
      end
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
